// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per active cycle through a
// registered carry, with plain-add and accumulate modes plus carry-out and signed-overflow flags.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2   // must divide WIDTH; 1 <= DIGIT <= WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             mode,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             state_dbg,
  output logic [WIDTH-1:0] acc_dbg
);

  // Handshake: start is a request that is taken only on an active edge while busy=0 (requests
  // while busy are dropped, nothing queues). done is high for one active cycle with sum/cout/ovf
  // valid; busy is already low then, so a new start may be raised in that same cycle.

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_next;
  logic             load, step, last;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [WIDTH-1:0] res_next;
  logic             a_msb, b_msb;
  logic [DIGIT:0]   slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  assign slice = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

  // Only the upper WIDTH-DIGIT result bits need storing; the final digit lands straight in sum.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_next = slice[DIGIT-1:0];
    end else begin : g_shift
      logic [WIDTH-DIGIT-1:0] res;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res <= '0;
        end else if (ena && step) begin
          res <= res_next[WIDTH-1:DIGIT];
        end
      end
      assign res_next = {slice[DIGIT-1:0], res};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
    end else if (ena) begin
      done <= last;
      if (load) begin
        op_a  <= a;
        op_b  <= mode ? acc : b;
        carry <= cin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= mode ? acc[WIDTH-1] : b[WIDTH-1];
      end else if (step) begin
        op_a  <= op_a >> DIGIT;
        op_b  <= op_b >> DIGIT;
        carry <= slice[DIGIT];
        cnt   <= cnt + CW'(1);
      end
      if (last) begin
        sum  <= res_next;
        cout <= slice[DIGIT];
        ovf  <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
      end
      // clr wins over the completion write-back.
      if (clr) begin
        acc <= '0;
      end else if (last) begin
        acc <= res_next;
      end
    end
  end

  assign busy      = (state == BUSY);
  assign state_dbg = state;
  assign acc_dbg   = acc;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: hand-computed vectors on the 8/2 build, plus a
// model-checked sweep of the 8/1 and 16/4 builds.
module tb_digit_serial_adder;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0, mode = 1'b0, clr = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf, state_dbg;
  logic [7:0] sum, acc_dbg;

  logic       p_start = 1'b0, p_mode = 1'b0, p_cin = 1'b0, tie_clr = 1'b0;
  logic [7:0] p_a = '0, p_b = '0;
  logic       p_busy, p_done, p_cout, p_ovf, p_state;
  logic [7:0] p_sum, p_acc;

  logic        q_start = 1'b0, q_mode = 1'b0, q_cin = 1'b0;
  logic [15:0] q_a = '0, q_b = '0;
  logic        q_busy, q_done, q_cout, q_ovf, q_state;
  logic [15:0] q_sum, q_acc;

  int n_checks = 0;
  int n_pass = 0;
  int cycle = 0;
  int lat, busy_cycles, done_cycle;

  logic [9:0]  exp8_q[$];
  logic [17:0] exp16_q[$];

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .mode(mode), .clr(clr),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .ovf(ovf), .state_dbg(state_dbg), .acc_dbg(acc_dbg)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(p_start), .mode(p_mode), .clr(tie_clr),
    .a(p_a), .b(p_b), .cin(p_cin), .busy(p_busy), .done(p_done), .sum(p_sum), .cout(p_cout),
    .ovf(p_ovf), .state_dbg(p_state), .acc_dbg(p_acc)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut_q (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(q_start), .mode(q_mode), .clr(tie_clr),
    .a(q_a), .b(q_b), .cin(q_cin), .busy(q_busy), .done(q_done), .sum(q_sum), .cout(q_cout),
    .ovf(q_ovf), .state_dbg(q_state), .acc_dbg(q_acc)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    full = {1'b0, x} + {1'b0, y} + {8'd0, c};
    return {(x[7] == y[7]) && (full[7] != x[7]), full[8], full[7:0]};
  endfunction

  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] full;
    full = {1'b0, x} + {1'b0, y} + {16'd0, c};
    return {(x[15] == y[15]) && (full[15] != x[15]), full[16], full[15:0]};
  endfunction

  // Drives one start at a negedge and returns at the negedge where done is seen (or after 40
  // cycles). lat counts active-or-stalled edges after the start edge.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic imode, input bit clr_last, input int stall_at,
                       input int stall_len, input bit poke_start);
    a = ia; b = ib; cin = icin; mode = imode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      if (clr_last && lat == N - 1) clr = 1'b1;
      if (lat == stall_at) ena = 1'b0;
      if (lat == stall_at + stall_len) ena = 1'b1;
      if (poke_start && lat == 1) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end
      @(negedge clk);
      lat++;
      clr = 1'b0;
      start = 1'b0;
    end
    done_cycle = cycle;
    ena = 1'b1;
  endtask

  initial begin
    int t0, ndone, plat, qlat, k;
    bit pgot, qgot;
    logic [7:0]  pacc, pb_eff;
    logic [15:0] qacc, qb_eff;
    logic [9:0]  pe;
    logic [17:0] qe;

    // reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_acc", 32'(acc_dbg), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic add
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 0, -1, 0, 0);
    check("t1_lat", 32'(lat), 32'd4);
    check("t1_busy_cycles", 32'(busy_cycles), 32'd4);
    check("t1_sum", 32'(sum), 32'h7F);
    check("t1_cout", 32'(cout), 32'd0);
    check("t1_ovf", 32'(ovf), 32'd0);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_sum_held", 32'(sum), 32'h7F);

    // 2: carry and overflow corners
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, -1, 0, 0);
    check("t2a_sum", 32'(sum), 32'h00);
    check("t2a_cout", 32'(cout), 32'd1);
    check("t2a_ovf", 32'(ovf), 32'd0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, -1, 0, 0);
    check("t2b_sum", 32'(sum), 32'h80);
    check("t2b_cout", 32'(cout), 32'd0);
    check("t2b_ovf", 32'(ovf), 32'd1);
    do_op(8'h80, 8'hFF, 1'b1, 1'b0, 0, -1, 0, 0);
    check("t2c_sum", 32'(sum), 32'h80);
    check("t2c_cout", 32'(cout), 32'd1);
    check("t2c_ovf", 32'(ovf), 32'd0);

    // 3: accumulate, back-to-back on the done cycle
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t3_acc_clr", 32'(acc_dbg), 32'd0);
    do_op(8'h10, 8'h55, 1'b0, 1'b1, 0, -1, 0, 0);
    check("t3_sum1", 32'(sum), 32'h10);
    t0 = done_cycle;
    do_op(8'h10, 8'h55, 1'b0, 1'b1, 0, -1, 0, 0);
    check("t3_sum2", 32'(sum), 32'h20);
    check("t3_spacing2", 32'(done_cycle - t0), 32'd5);
    t0 = done_cycle;
    do_op(8'h10, 8'h55, 1'b0, 1'b1, 0, -1, 0, 0);
    check("t3_sum3", 32'(sum), 32'h30);
    check("t3_spacing3", 32'(done_cycle - t0), 32'd5);
    check("t3_acc3", 32'(acc_dbg), 32'h30);
    do_op(8'h10, 8'h55, 1'b0, 1'b1, 1, -1, 0, 0);
    check("t3_sum4", 32'(sum), 32'h40);
    check("t3_acc_clr_wins", 32'(acc_dbg), 32'd0);
    do_op(8'h01, 8'h77, 1'b0, 1'b1, 0, -1, 0, 0);
    check("t3_sum5", 32'(sum), 32'h01);

    // 4: stall for 3 cycles after the second digit edge, start poked while busy
    @(negedge clk);
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 2, 3, 1);
    check("t4_lat", 32'(lat), 32'd7);
    check("t4_sum", 32'(sum), 32'h46);
    check("t4_cout", 32'(cout), 32'd0);
    check("t4_ovf", 32'(ovf), 32'd0);
    ena = 1'b0;
    @(negedge clk);
    check("t4_done_stretch", 32'(done), 32'd1);
    ena = 1'b1;
    @(negedge clk);
    check("t4_done_drop", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("t4_no_extra_op", 32'(ndone), 32'd0);

    // 5: async reset mid-operation
    a = 8'h55; b = 8'h11; cin = 1'b0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_acc", 32'(acc_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("t5_no_done_after_release", 32'(ndone), 32'd0);
    do_op(8'h01, 8'h02, 1'b0, 1'b0, 0, -1, 0, 0);
    check("t5_lat", 32'(lat), 32'd4);
    check("t5_sum", 32'(sum), 32'h03);

    // 6: parameter sweep against the arithmetic model
    pacc = '0;
    qacc = '0;
    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      p_a = 8'($urandom_range(0, 255));
      p_b = 8'($urandom_range(0, 255));
      p_cin = 1'($urandom_range(0, 1));
      p_mode = (v % 4 == 3);
      q_a = 16'($urandom_range(0, 65535));
      q_b = 16'($urandom_range(0, 65535));
      q_cin = 1'($urandom_range(0, 1));
      q_mode = (v % 5 == 4);
      if (v == 0) begin p_a = 8'h7F; p_b = 8'h7F; q_a = 16'hFFFF; q_b = 16'hFFFF; end
      pb_eff = p_mode ? pacc : p_b;
      qb_eff = q_mode ? qacc : q_b;
      pe = ref8(p_a, pb_eff, p_cin);
      qe = ref16(q_a, qb_eff, q_cin);
      pacc = pe[7:0];
      qacc = qe[15:0];
      exp8_q.push_back(pe);
      exp16_q.push_back(qe);
      p_start = 1'b1;
      q_start = 1'b1;
      @(negedge clk);
      p_start = 1'b0;
      q_start = 1'b0;
      pgot = 0; qgot = 0; plat = -1; qlat = -1; k = 0;
      while (!(pgot && qgot) && k < 40) begin
        if (p_done && !pgot) begin
          pgot = 1;
          plat = k;
          pe = exp8_q.pop_front();
          check("p_sum", 32'(p_sum), 32'(pe[7:0]));
          check("p_cout", 32'(p_cout), 32'(pe[8]));
          check("p_ovf", 32'(p_ovf), 32'(pe[9]));
        end
        if (q_done && !qgot) begin
          qgot = 1;
          qlat = k;
          qe = exp16_q.pop_front();
          check("q_sum", 32'(q_sum), 32'(qe[15:0]));
          check("q_cout", 32'(q_cout), 32'(qe[16]));
          check("q_ovf", 32'(q_ovf), 32'(qe[17]));
        end
        if (!(pgot && qgot)) begin
          @(negedge clk);
          k++;
        end
      end
      check("p_lat", 32'(plat), 32'd8);
      check("q_lat", 32'(qlat), 32'd4);
    end
    check("p_queue_empty", 32'(exp8_q.size()), 32'd0);
    check("q_queue_empty", 32'(exp16_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised, multi-cycle successor to the team's combinational half adder. Adds two WIDTH-bit operands DIGIT bits per cycle using a registered carry. Supports plain add and accumulate modes, with carry-out and signed-overflow flags. Sits behind the tt_um user-project wrapper, driven from ui_in/uio_in and observed on uo_out.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits processed per active cycle; legal range 1..WIDTH.

Ports:
clk    input   1      clock, rising edge
rst_n  input   1      asynchronous active-low reset
ena    input   1      clock enable; 0 freezes all state (reset still acts)
start  input   1      request operation; sampled in IDLE only
mode   input   1      0 = a+b+cin, 1 = acc+a+cin
clr    input   1      synchronous clear of accumulator
a      input   WIDTH  operand A
b      input   WIDTH  operand B (ignored when mode=1)
cin    input   1      carry in
busy   output  1      operation in progress
done   output  1      one-cycle pulse: result valid
sum    output  WIDTH  result, held until next completion
cout   output  1      carry out of MSB
ovf    output  1      two's-complement overflow

Behaviour:
- N = WIDTH/DIGIT. Digit counter width is clog2(N), minimum 1.
- Reset (async, rst_n=0): state=IDLE; busy, done, sum, cout, ovf, acc, carry and counter all 0. Outputs go 0 immediately, not at the next edge. An in-flight operation is abandoned, and no done follows release.
- All non-reset updates occur only on edges where ena=1. With ena=0, state, counter, carry and outputs hold. done also holds, so its pulse stretches while ena=0.
- IDLE: busy=0. On an edge with start=1:
  - latch a into opA;
  - latch b into opB (mode=0) or acc into opB (mode=1);
  - latch cin into the carry register;
  - set counter=0; go to BUSY; busy=1 from this edge.
- BUSY, each active edge:
  - slice = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry (DIGIT+1 bits);
  - shift slice[DIGIT-1:0] into the result shift register from the MSB side;
  - shift opA and opB right by DIGIT; carry <= slice[DIGIT];
  - counter++.
- On the edge processing digit N-1:
  - sum <= full result; cout <= final carry;
  - ovf <= (opA_msb == opB_msb) && (sum_msb != opA_msb), using the original operand MSBs (keep copies);
  - done <= 1; busy <= 0; state <= IDLE;
  - acc <= result, unless clr=1 on that edge.
- done clears on the next active edge.
- Latency: start edge = edge 0; done is high after edge N.
- start is accepted on the done cycle, giving back-to-back throughput of one result per N+1 cycles.
- start while BUSY is ignored; no queueing.
- Operand inputs are don't-care after the start edge.
- clr=1 on an active edge sets acc=0 in any state, and takes priority over the completion write. clr does not affect sum, opB already latched, or the operation in flight.
- Overflow wraps: sum is modulo 2^WIDTH.

Test Plan:
(WIDTH=8, DIGIT=2, N=4)
1. a=0x35, b=0x4A, cin=0, mode=0, start one cycle -> busy for 4 cycles; done pulse 4 edges after start; sum=0x7F, cout=0, ovf=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0xFF, cin=1 -> sum=0x80, cout=1, ovf=0.
3. Accumulate: pulse clr, then three mode=1 ops with a=0x10, each started on the previous done cycle:
   - required sums 0x10, 0x20, 0x30;
   - done spacing of 5 cycles.
   Then clr asserted on the completion edge -> sum=0x40 but acc=0, so the next op with a=0x01 gives 0x01.
4. Stall: a=0x12, b=0x34; drop ena for 3 cycles after the second BUSY edge -> done arrives exactly 3 cycles late, sum=0x46. Also start pulsed while busy -> ignored, single done.
5. Reset: assert rst_n=0 mid-BUSY, asynchronously between edges -> busy, done, sum, acc read 0 before the next edge. No done after release. A fresh op (a=0x01, b=0x02) then gives 0x03.
6. Parameter sweep: (WIDTH=8, DIGIT=1) and (WIDTH=16, DIGIT=4) with random operands against a reference model -> latency of N and correct sum, cout and ovf on all vectors.
